// File: rtl/sobel_row_buffer_if.sv
// sobel_row_buffer_if
// Bundles the row buffer's strip control, memory read, accelerator window
// and write-stage handshake signals. The row buffer itself uses the slave
// modport; whatever drives it (controller, memory path, write stage) uses master.
interface sobel_row_buffer_if #(
  parameter int IDATA_W  = 80,
  parameter int ROWCNT_W = 16
);
  logic                sctl2srow_strip_start;
  logic [ROWCNT_W-1:0] sctl2srow_row_count;
  logic [IDATA_W-1:0]  mem2srow_read_data;
  logic                mem2srow_read_valid;
  logic                srow2mem_read_ready;
  logic [IDATA_W-1:0]  srow2sacc_row1_data;
  logic [IDATA_W-1:0]  srow2sacc_row2_data;
  logic [IDATA_W-1:0]  srow2sacc_row3_data;
  logic                srow2swt_valid;
  logic                swt2srow_ready;
  logic                srow2sctl_strip_done;

  modport master (
    output sctl2srow_strip_start, sctl2srow_row_count,
    output mem2srow_read_data, mem2srow_read_valid, swt2srow_ready,
    input  srow2mem_read_ready, srow2sacc_row1_data, srow2sacc_row2_data,
    input  srow2sacc_row3_data, srow2swt_valid, srow2sctl_strip_done
  );

  modport slave (
    input  sctl2srow_strip_start, sctl2srow_row_count,
    input  mem2srow_read_data, mem2srow_read_valid, swt2srow_ready,
    output srow2mem_read_ready, srow2sacc_row1_data, srow2sacc_row2_data,
    output srow2sacc_row3_data, srow2swt_valid, srow2sctl_strip_done
  );
endinterface

// File: rtl/sobel_row_buffer.sv
// sobel_row_buffer
// Three-row sliding window in front of the Sobel accelerator cores. Row beats
// arrive one per valid/ready transfer; once three rows are held the window is
// offered to the write stage, one window per cycle while both sides stream.
// NUM_ACC must match the accelerator count used elsewhere in the design, and
// the interface must be built with IDATA_W = (NUM_ACC+2)*PIXEL_W.
//
// Optional feature, macro SOBEL_ROW_ZERO_PAD_EN: a virtual all-zero row is
// placed before the first and after the last row of each strip, so a strip of
// N rows yields N windows instead of N-2.
module sobel_row_buffer #(
  parameter int NUM_ACC  = 8,
  parameter int PIXEL_W  = 8,
  parameter int ROWCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  sobel_row_buffer_if.slave bus
);

  localparam int IDATA_W = (NUM_ACC + 2) * PIXEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [ROWCNT_W-1:0]     row_count_reg, row_count_next;
  logic [ROWCNT_W-1:0]     rows_in_reg, rows_in_next;
  logic [1:0]              fill_reg, fill_next;
  // win_reg[0] is the oldest (top) row, win_reg[2] the newest (bottom) row
  logic [2:0][IDATA_W-1:0] win_reg;

  logic                    read_ready;
  logic                    shift_en;
  logic                    shift_zero;
  logic                    clear_rows;
  logic                    rows_left;
  logic                    last_beat;
  logic [IDATA_W-1:0]      shift_data;

`ifdef SOBEL_ROW_ZERO_PAD_EN
  // set once the trailing virtual zero row has been shifted in
  logic                    pad_done_reg, pad_done_next;
`endif

  // rows_in never passes row_count, so rows_left also gates read_ready
  assign rows_left  = (rows_in_reg < row_count_reg);
  assign last_beat  = ((rows_in_reg + ROWCNT_W'(1)) == row_count_reg);
  assign shift_data = shift_zero ? '0 : bus.mem2srow_read_data;

  // next-state, read-ready and window-shift decisions
  always_comb begin
    state_next     = state_reg;
    row_count_next = row_count_reg;
    rows_in_next   = rows_in_reg;
    fill_next      = fill_reg;
    read_ready     = 1'b0;
    shift_en       = 1'b0;
    shift_zero     = 1'b0;
    clear_rows     = 1'b0;
`ifdef SOBEL_ROW_ZERO_PAD_EN
    pad_done_next  = pad_done_reg;
`endif

    if (bus.sctl2srow_strip_start) begin
      // a strip start wins in every state; any beat offered now is refused
      state_next     = ST_FILL;
      row_count_next = bus.sctl2srow_row_count;
      rows_in_next   = '0;
`ifdef SOBEL_ROW_ZERO_PAD_EN
      fill_next      = 2'd1;
      clear_rows     = 1'b1;
      pad_done_next  = 1'b0;
`else
      fill_next      = 2'd0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end

        ST_FILL: begin
          read_ready = rows_left;
          if (rows_left) begin
            if (bus.mem2srow_read_valid) begin
              shift_en     = 1'b1;
              rows_in_next = rows_in_reg + ROWCNT_W'(1);
              fill_next    = fill_reg + 2'd1;
              if (fill_reg == 2'd2) begin
                state_next = ST_RUN;
              end
`ifndef SOBEL_ROW_ZERO_PAD_EN
              else if (last_beat) begin
                // strip too short to ever form a window
                state_next = ST_DONE;
              end
`endif
            end
          end else begin
`ifdef SOBEL_ROW_ZERO_PAD_EN
            // a single real row still yields one window between two zero rows
            if (fill_reg == 2'd2 && !pad_done_reg) begin
              shift_en      = 1'b1;
              shift_zero    = 1'b1;
              pad_done_next = 1'b1;
              fill_next     = 2'd3;
              state_next    = ST_RUN;
            end else begin
              state_next = ST_DONE;
            end
`else
            state_next = ST_DONE;
`endif
          end
        end

        ST_RUN: begin
          // a new row may only enter when the current window is being consumed
          read_ready = bus.swt2srow_ready && rows_left;
          if (bus.swt2srow_ready) begin
            if (rows_left && bus.mem2srow_read_valid) begin
              shift_en     = 1'b1;
              rows_in_next = rows_in_reg + ROWCNT_W'(1);
            end else if (rows_left) begin
              // memory stalled: two rows remain valid, one beat restores a window
              state_next = ST_FILL;
              fill_next  = 2'd2;
            end else begin
`ifdef SOBEL_ROW_ZERO_PAD_EN
              if (!pad_done_reg) begin
                shift_en      = 1'b1;
                shift_zero    = 1'b1;
                pad_done_next = 1'b1;
              end else begin
                state_next = ST_DONE;
              end
`else
              state_next = ST_DONE;
`endif
            end
          end
        end

        ST_DONE: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // state, counters and window registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      row_count_reg <= '0;
      rows_in_reg   <= '0;
      fill_reg      <= '0;
      win_reg       <= '0;
`ifdef SOBEL_ROW_ZERO_PAD_EN
      pad_done_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      row_count_reg <= row_count_next;
      rows_in_reg   <= rows_in_next;
      fill_reg      <= fill_next;
`ifdef SOBEL_ROW_ZERO_PAD_EN
      pad_done_reg  <= pad_done_next;
`endif
      if (clear_rows) begin
        win_reg <= '0;
      end else if (shift_en) begin
        win_reg <= {shift_data, win_reg[2], win_reg[1]};
      end
    end
  end

  assign bus.srow2mem_read_ready  = read_ready;
  assign bus.srow2sacc_row1_data  = win_reg[0];
  assign bus.srow2sacc_row2_data  = win_reg[1];
  assign bus.srow2sacc_row3_data  = win_reg[2];
  assign bus.srow2swt_valid       = (state_reg == ST_RUN);
  assign bus.srow2sctl_strip_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sobel_row_buffer.sv
// tb_sobel_row_buffer
// Randomized and directed strips; expected windows are the consecutive row
// triples of each strip (with zero rows at both ends when SOBEL_ROW_ZERO_PAD_EN
// is defined) and are queued when the strip is issued. A monitor pops and
// compares on every consumed window, checks that held windows stay stable and
// counts done pulses.
module tb_sobel_row_buffer;

  localparam int NUM_ACC  = 8;
  localparam int PIXEL_W  = 8;
  localparam int ROWCNT_W = 16;
  localparam int IDATA_W  = (NUM_ACC + 2) * PIXEL_W;
`ifdef SOBEL_ROW_ZERO_PAD_EN
  localparam int FILL_BEATS = 2;
`else
  localparam int FILL_BEATS = 3;
`endif

  typedef logic [IDATA_W-1:0] row_t;
  typedef struct packed {
    row_t r1;
    row_t r2;
    row_t r3;
  } win_t;

  logic clk;
  logic reset_n;

  sobel_row_buffer_if #(.IDATA_W(IDATA_W), .ROWCNT_W(ROWCNT_W)) bus ();

  sobel_row_buffer #(
    .NUM_ACC (NUM_ACC),
    .PIXEL_W (PIXEL_W),
    .ROWCNT_W(ROWCNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int done_cyc = -1;
  int last_consume_cyc = -1;
  int last_accept_cyc = -1;

  win_t exp_q[$];
  row_t cur_beats[$];
  int   cur_idx = 0;
  int   cur_nw = 0;
  logic [ROWCNT_W-1:0] cur_rc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_win(input string name, input win_t act, input win_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic row_t rand_row();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[IDATA_W-1:0];
  endfunction

  // ---------------------------------------------------------------- monitor
  logic prev_hold = 1'b0;
  win_t prev_win;
  win_t mon_win;

  // compare consumed windows, held-window stability and done pulses
  always @(negedge clk) begin
    mon_win = {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data};
    if (prev_hold) begin
      check_bit("hold_valid", bus.srow2swt_valid, 1'b1);
      check_win("hold_window", mon_win, prev_win);
    end
    if (reset_n && bus.srow2swt_valid && bus.swt2srow_ready) begin
      last_consume_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got %0h, required no window (cycle %0d)", mon_win, cyc);
      end else begin
        check_win("window", mon_win, exp_q.pop_front());
      end
    end
    if (reset_n && bus.srow2sctl_strip_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_hold = reset_n && bus.srow2swt_valid && !bus.swt2srow_ready && !bus.sctl2srow_strip_start;
    prev_win  = mon_win;
  end

  // ---------------------------------------------------------------- driver
  task automatic step(input logic rst_n, input logic ss, input logic rv, input row_t rd, input logic sr);
    @(posedge clk);
    #1;
    reset_n                   = rst_n;
    bus.sctl2srow_strip_start = ss;
    bus.sctl2srow_row_count   = cur_rc;
    bus.mem2srow_read_valid   = rv;
    bus.mem2srow_read_data    = rd;
    bus.swt2srow_ready        = sr;
    @(negedge clk);
  endtask

  task automatic step_beat(input logic rv, input logic sr, output logic acc);
    logic v;
    v = rv && (cur_idx < cur_beats.size());
    step(1'b1, 1'b0, v, v ? cur_beats[cur_idx] : rand_row(), sr);
    acc = v && bus.srow2mem_read_ready;
    if (acc) begin
      cur_idx++;
      last_accept_cyc = cyc;
    end
  endtask

  // build a strip of n random rows; optionally queue its expected windows
  task automatic start_strip(input int n, input bit expect_it);
    row_t l[$];
    win_t w;
    cur_beats.delete();
    for (int i = 0; i < n; i++) cur_beats.push_back(rand_row());
    cur_idx = 0;
    cur_rc  = ROWCNT_W'(n);
    cur_nw  = 0;
    if (expect_it) begin
`ifdef SOBEL_ROW_ZERO_PAD_EN
      l.push_back('0);
`endif
      foreach (cur_beats[i]) l.push_back(cur_beats[i]);
`ifdef SOBEL_ROW_ZERO_PAD_EN
      l.push_back('0);
`endif
      for (int i = 0; i + 2 < l.size(); i++) begin
        w.r1 = l[i];
        w.r2 = l[i+1];
        w.r3 = l[i+2];
        exp_q.push_back(w);
        cur_nw++;
      end
      exp_done++;
    end
    // a beat is offered alongside strip_start and must be refused
    step(1'b1, 1'b1, 1'b1, (n > 0) ? cur_beats[0] : rand_row(), 1'b0);
    check_bit("start_cycle_ready", bus.srow2mem_read_ready, 1'b0);
  endtask

  // run the current strip to its done pulse with random valid/ready activity
  task automatic feed(input int pv, input int pr);
    logic acc;
    int   budget;
    budget = 0;
    while (done_cnt < exp_done && budget < 2000) begin
      step_beat($urandom_range(99) < pv, $urandom_range(99) < pr, acc);
      budget++;
    end
    check_int("strip_done_count", done_cnt, exp_done);
    check_int("beats_accepted", cur_idx, cur_beats.size());
    check_int("windows_outstanding", exp_q.size(), 0);
    if (cur_nw > 0) begin
      check_int("done_after_last_consume", done_cyc, last_consume_cyc + 1);
    end else if (cur_beats.size() > 0) begin
      check_int("done_after_last_beat", done_cyc, last_accept_cyc + 1);
    end
  endtask

  logic acc;

  initial begin
    reset_n                   = 1'b0;
    bus.sctl2srow_strip_start = 1'b0;
    bus.sctl2srow_row_count   = '0;
    bus.mem2srow_read_valid   = 1'b0;
    bus.mem2srow_read_data    = '0;
    bus.swt2srow_ready        = 1'b0;

    // reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_bit("reset_valid", bus.srow2swt_valid, 1'b0);
    check_bit("reset_ready", bus.srow2mem_read_ready, 1'b0);
    check_bit("reset_done", bus.srow2sctl_strip_done, 1'b0);
    check_win("reset_rows", {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data}, '0);
    step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
    check_bit("idle_ready", bus.srow2mem_read_ready, 1'b0);

    // five rows back-to-back, write stage always ready
    start_strip(5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step_beat(1'b1, 1'b1, acc);
      check_bit("stream_ready", acc, 1'b1);
      check_bit("stream_valid", bus.srow2swt_valid, (k >= FILL_BEATS));
    end
    feed(100, 100);

    // two-row strip: no window, done right after the last beat
    start_strip(2, 1'b1);
    feed(100, 100);

    // write stage stalls in RUN while memory keeps offering a beat
    start_strip(6, 1'b1);
    for (int k = 0; k < FILL_BEATS; k++) step_beat(1'b1, 1'b0, acc);
    for (int k = 0; k < 4; k++) begin
      step_beat(1'b1, 1'b0, acc);
      check_bit("stall_ready", bus.srow2mem_read_ready, 1'b0);
      check_bit("stall_valid", bus.srow2swt_valid, 1'b1);
      check_win("stall_window", {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data}, exp_q[0]);
    end
    feed(100, 100);

    // strip_start while a window is held: abort and restart
    start_strip(4, 1'b0);
    for (int k = 0; k < FILL_BEATS; k++) step_beat(1'b1, 1'b0, acc);
    step_beat(1'b0, 1'b0, acc);
    check_bit("abort_pre_valid", bus.srow2swt_valid, 1'b1);
    start_strip(4, 1'b1);
    step_beat(1'b1, 1'b1, acc);
    check_bit("abort_post_valid", bus.srow2swt_valid, 1'b0);
    feed(70, 70);

    // reset asserted in the middle of RUN
    start_strip(5, 1'b0);
    for (int k = 0; k < FILL_BEATS; k++) step_beat(1'b1, 1'b0, acc);
    step_beat(1'b0, 1'b0, acc);
    check_bit("midrun_valid", bus.srow2swt_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_bit("midreset_valid", bus.srow2swt_valid, 1'b0);
    check_bit("midreset_ready", bus.srow2mem_read_ready, 1'b0);
    check_bit("midreset_done", bus.srow2sctl_strip_done, 1'b0);
    check_win("midreset_rows", {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data}, '0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1, rand_row(), 1'b1);
      check_bit("postreset_valid", bus.srow2swt_valid, 1'b0);
      check_bit("postreset_ready", bus.srow2mem_read_ready, 1'b0);
    end

    // random strips
    for (int s = 0; s < 25; s++) begin
      start_strip($urandom_range(0, 9), 1'b1);
      feed($urandom_range(30, 100), $urandom_range(30, 100));
    end

    // no stray done pulses afterwards
    repeat (5) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check_int("final_done_count", done_cnt, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
